// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (word read), held until if_ready
//   if_ready/if_rdata/if_err      one-cycle fetch response
//   d_req_rd/d_req_wr/d_size/     load/store request (byte/half/word), store wins
//   d_unsigned/d_addr/d_wdata     if both rd and wr are high
//   d_ready/d_rdata/d_err         one-cycle data response, aligned/extended load data
//   stall_if/stall_mem            combinational pipeline stalls
//   mem_req/mem_we/mem_addr/      memory strobe and registered access fields,
//   mem_wdata/mem_be              held stable until mem_ready or timeout
//   mem_ready/mem_rdata           memory completion and read word

module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req_rd,
    input  logic        d_req_wr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    localparam logic [3:0] MAX_S  = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [3:0]  streak;
    logic [7:0]  tmo_cnt;
    logic [1:0]  lat_lo;
    logic [1:0]  lat_size;
    logic        lat_uns;

    logic        d_pend;
    logic        misalign;
    logic        grant_d, grant_if, done_ok, done_tmo;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Fetch addresses are word addresses; the low bits are don't-care.
    logic unused_if_lo;
    assign unused_if_lo = ^if_addr[1:0];

    assign d_pend    = d_req_rd | d_req_wr;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_pend & ~d_ready;

    // Size 11 behaves as a word access.
    assign misalign = ((d_size == 2'b01) & d_addr[0]) |
                      (d_size[1] & (d_addr[1:0] != 2'b00));

    always_comb begin
        req_be = 4'hF;
        case (d_size)
            2'b00:   req_be = 4'b0001 << d_addr[1:0];
            2'b01:   req_be = 4'b0011 << d_addr[1:0];
            default: req_be = 4'hF;
        endcase
    end

    assign req_wdata = d_wdata << {d_addr[1:0], 3'b000};

    // Load alignment uses the offset/size latched at grant time.
    assign shifted = mem_rdata >> {lat_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (lat_size)
            2'b00:   load_data = lat_uns ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = lat_uns ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        done_ok    = 1'b0;
        done_tmo   = 1'b0;
        case (state)
            IDLE: begin
                // Data has priority unless it has already won MAX_DATA_STREAK
                // grants in a row while fetch was waiting.
                if (d_pend && ((streak < MAX_S) || !if_req)) begin
                    grant_d    = 1'b1;
                    state_next = misalign ? RESP : BUSY_D;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (tmo_cnt == TMO_M1) begin
                    done_tmo   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_ready  <= 1'b0;
            if_rdata  <= 32'h0;
            if_err    <= 1'b0;
            d_ready   <= 1'b0;
            d_rdata   <= 32'h0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            streak    <= 4'h0;
            tmo_cnt   <= 8'h0;
            lat_lo    <= 2'b00;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
        end else begin
            // Ready pulses are only set on the edge into RESP, which lasts one cycle.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (state == IDLE) begin
                if (grant_if || !if_req)
                    streak <= 4'h0;
                else if (grant_d && (streak != MAX_S))
                    streak <= streak + 4'd1;
            end

            if (grant_d) begin
                lat_lo   <= d_addr[1:0];
                lat_size <= d_size;
                lat_uns  <= d_unsigned;
                if (misalign) begin
                    d_ready <= 1'b1;
                    d_err   <= 1'b1;
                    d_rdata <= 32'h0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= d_req_wr;
                    mem_addr  <= {d_addr[31:2], 2'b00};
                    mem_be    <= d_req_wr ? req_be : 4'hF;
                    mem_wdata <= d_req_wr ? req_wdata : 32'h0;
                end
            end

            if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= {if_addr[31:2], 2'b00};
                mem_be    <= 4'hF;
                mem_wdata <= 32'h0;
            end

            if ((state == BUSY_IF) || (state == BUSY_D)) begin
                if (done_ok || done_tmo) begin
                    mem_req <= 1'b0;
                    tmo_cnt <= 8'h0;
                    if (state == BUSY_D) begin
                        d_ready <= 1'b1;
                        d_err   <= done_tmo;
                        d_rdata <= (done_ok && !mem_we) ? load_data : 32'h0;
                    end else begin
                        if_ready <= 1'b1;
                        if_err   <= done_tmo;
                        if_rdata <= done_ok ? mem_rdata : 32'h0;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready, if_err;
    logic [31:0] if_rdata;
    logic        d_req_rd, d_req_wr, d_unsigned;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ready, d_err;
    logic        stall_if, stall_mem;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        mem_en, force_rdy;
    int          ncheck = 0;
    int          nfail  = 0;

    // Memory model: completes in the same cycle the strobe is seen.
    assign mem_ready = (mem_req & mem_en) | force_rdy;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] drdata;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic [3:0] be,
                                logic [31:0] mwdata, logic [31:0] drdata, logic err);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.be = be; v.mwdata = mwdata; v.drdata = drdata; v.err = err;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_data(input int idx);
        vec_t        v;
        int          cyc;
        logic        saw;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        v = vecs[idx];
        saw = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        tick;
        d_req_rd = ~v.wr; d_req_wr = v.wr; d_size = v.size; d_unsigned = v.uns;
        d_addr = v.addr; d_wdata = v.wdata; mem_rdata = v.rdata;
        #1;
        check($sformatf("v%0d stall_mem_wait", idx), {31'h0, stall_mem}, 32'h1);
        cyc = 0;
        while (!d_ready && cyc < 10) begin
            tick;
            cyc++;
            if (mem_req) begin
                saw = 1'b1; c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
            end
        end
        check($sformatf("v%0d d_ready_seen", idx), {31'h0, d_ready}, 32'h1);
        check($sformatf("v%0d latency", idx), cyc, v.err ? 32'd1 : 32'd2);
        check($sformatf("v%0d d_err", idx), {31'h0, d_err}, {31'h0, v.err});
        check($sformatf("v%0d stall_mem_done", idx), {31'h0, stall_mem}, 32'h0);
        if (v.err) begin
            check($sformatf("v%0d no_mem_req", idx), {31'h0, saw}, 32'h0);
        end else begin
            check($sformatf("v%0d d_rdata", idx), d_rdata, v.drdata);
            check($sformatf("v%0d mem_addr", idx), c_addr, v.addr & ~32'h3);
            check($sformatf("v%0d mem_be", idx), {28'h0, c_be}, {28'h0, v.be});
            check($sformatf("v%0d mem_wdata", idx), c_wdata, v.mwdata);
            check($sformatf("v%0d mem_we", idx), {31'h0, c_we}, {31'h0, v.wr});
        end
        d_req_rd = 1'b0; d_req_wr = 1'b0;
    endtask

    initial begin
        int          cyc, n, ng, nrdy;
        logic [31:0] grants[7];
        logic [31:0] exp_g[7];

        vecs[0]  = mk(0, 2'b00, 0, 32'h203, 0, 32'h80123456, 4'hF, 0, 32'hFFFFFF80, 0);
        vecs[1]  = mk(0, 2'b00, 1, 32'h203, 0, 32'h80123456, 4'hF, 0, 32'h00000080, 0);
        vecs[2]  = mk(0, 2'b01, 0, 32'h202, 0, 32'h80017777, 4'hF, 0, 32'hFFFF8001, 0);
        vecs[3]  = mk(0, 2'b01, 1, 32'h200, 0, 32'h1234F00D, 4'hF, 0, 32'h0000F00D, 0);
        vecs[4]  = mk(0, 2'b10, 0, 32'h204, 0, 32'hCAFEBABE, 4'hF, 0, 32'hCAFEBABE, 0);
        vecs[5]  = mk(0, 2'b00, 0, 32'h201, 0, 32'h00007F00, 4'hF, 0, 32'h0000007F, 0);
        vecs[6]  = mk(1, 2'b01, 0, 32'h302, 32'h1234, 32'hFFFFFFFF, 4'b1100, 32'h12340000, 0, 0);
        vecs[7]  = mk(1, 2'b00, 0, 32'h301, 32'hAB, 32'hFFFFFFFF, 4'b0010, 32'h0000AB00, 0, 0);
        vecs[8]  = mk(1, 2'b10, 0, 32'h300, 32'h11223344, 32'hFFFFFFFF, 4'hF, 32'h11223344, 0, 0);
        vecs[9]  = mk(0, 2'b10, 0, 32'h301, 0, 32'h0, 4'hF, 0, 0, 1);
        vecs[10] = mk(0, 2'b01, 0, 32'h303, 0, 32'h0, 4'hF, 0, 0, 1);
        vecs[11] = mk(0, 2'b11, 0, 32'h208, 0, 32'h13572468, 4'hF, 0, 32'h13572468, 0);

        rst = 1'b1; if_req = 0; if_addr = 0; d_req_rd = 0; d_req_wr = 0; d_size = 0;
        d_unsigned = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_en = 1; force_rdy = 0;
        repeat (3) tick;
        check("rst if_ready", {31'h0, if_ready}, 32'h0);
        check("rst d_ready", {31'h0, d_ready}, 32'h0);
        check("rst errs", {30'h0, if_err, d_err}, 32'h0);
        check("rst rdata", if_rdata | d_rdata, 32'h0);
        check("rst mem_req_we", {30'h0, mem_req, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_be", {28'h0, mem_be}, 32'h0);
        rst = 1'b0;

        // Fetch only.
        tick;
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        #1;
        check("fetch stall_if", {31'h0, stall_if}, 32'h1);
        cyc = 0;
        while (!if_ready && cyc < 10) begin
            tick;
            cyc++;
            if (mem_req) begin
                check("fetch mem_addr", mem_addr, 32'h100);
                check("fetch mem_be", {28'h0, mem_be}, 32'hF);
                check("fetch mem_we", {31'h0, mem_we}, 32'h0);
            end
        end
        check("fetch latency", cyc, 32'd2);
        check("fetch if_rdata", if_rdata, 32'hDEADBEEF);
        check("fetch if_err", {31'h0, if_err}, 32'h0);
        check("fetch stall_if_done", {31'h0, stall_if}, 32'h0);
        if_req = 1'b0;

        // Loads, stores and misaligned accesses.
        for (int i = 0; i < 12; i++) do_data(i);

        // Data priority and the streak limit with both requesters always pending.
        tick;
        if_req = 1'b1; if_addr = 32'h400;
        d_req_rd = 1'b1; d_size = 2'b10; d_unsigned = 0; d_addr = 32'h200; mem_rdata = 32'h5;
        exp_g = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h400, 32'h200, 32'h200};
        ng = 0; cyc = 0;
        while (ng < 7 && cyc < 60) begin
            tick;
            cyc++;
            if (mem_req) begin
                grants[ng] = mem_addr;
                ng++;
            end
        end
        check("arb grant_count", ng, 32'd7);
        for (int i = 0; i < ng; i++) check($sformatf("arb grant%0d", i), grants[i], exp_g[i]);
        if_req = 1'b0; d_req_rd = 1'b0;
        repeat (3) tick;

        // Memory never answers: abort after TIMEOUT cycles, ignore a late ready.
        mem_en = 1'b0;
        d_req_rd = 1'b1; d_size = 2'b10; d_addr = 32'h200;
        n = 0; cyc = 0;
        while (!d_ready && cyc < 400) begin
            tick;
            cyc++;
            if (mem_req) n++;
        end
        check("tmo d_ready_seen", {31'h0, d_ready}, 32'h1);
        check("tmo mem_req_cycles", n, 32'd255);
        check("tmo d_err", {31'h0, d_err}, 32'h1);
        force_rdy = 1'b1;
        d_req_rd = 1'b0;
        tick;
        check("tmo late_ready pulse", {31'h0, d_ready}, 32'h0);
        check("tmo late_ready mem_req", {31'h0, mem_req}, 32'h0);
        force_rdy = 1'b0;
        tick;

        // Reset while the data access is outstanding.
        d_req_rd = 1'b1; d_size = 2'b10; d_addr = 32'h204;
        tick;
        tick;
        check("rstmid busy mem_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1; d_req_rd = 1'b0;
        tick;
        check("rstmid mem_req", {31'h0, mem_req}, 32'h0);
        check("rstmid d_ready", {31'h0, d_ready}, 32'h0);
        rst = 1'b0; mem_en = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (d_ready) nrdy++;
        end
        check("rstmid no_ready_after", nrdy, 32'd0);
        do_data(4);

        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
